// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant-owner
// encoding and the round-robin winner selection helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } grant_owner_e;

    // With both requesting, the side that did not win last time goes next;
    // a reset history of OWN_INST therefore favours DATA.
    function automatic grant_owner_e pick_winner(input logic inst_v,
                                                 input logic data_v,
                                                 input grant_owner_e last);
        if (inst_v && data_v) begin
            return (last == OWN_DATA) ? OWN_INST : OWN_DATA;
        end
        if (inst_v) begin
            return OWN_INST;
        end
        return OWN_DATA;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and shared-memory handshake signals around mem_arbiter.
// slave = arbiter side, master = CPU/memory side.
interface mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_ready;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_o;

    modport slave (
        input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
               mem_ack, mem_rdata,
        output inst_ready, inst_rdata, data_ready, data_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, stall_o
    );

    modport master (
        output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
               mem_ack, mem_rdata,
        input  inst_ready, inst_rdata, data_ready, data_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, stall_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one memory port, one transaction at a time.
// Define ARB_PERF_CNT_EN to add inst_grant_cnt / data_grant_cnt / stall_cnt outputs.
//
// state | meaning
// IDLE  | no transaction outstanding; arbitrate unmasked requests
// INST  | fetch issued on mem port, waiting for mem_ack
// DATA  | load/store issued on mem port, waiting for mem_ack
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]  inst_grant_cnt,
    output logic [31:0]  data_grant_cnt,
    output logic [31:0]  stall_cnt
`endif
);

    arb_state_e        state_q, state_d;
    grant_owner_e      last_grant_q, last_grant_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              inst_ready_q, inst_ready_d;
    logic              data_ready_q, data_ready_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

    logic              inst_cand;
    logic              data_cand;
    grant_owner_e      winner;
    logic              grant_v;

    // A requester whose ready pulse is showing this cycle is still holding req; mask it.
    assign inst_cand = bus.inst_req & ~inst_ready_q;
    assign data_cand = bus.data_req & ~data_ready_q;
    assign winner    = pick_winner(inst_cand, data_cand, last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        grant_v      = 1'b0;

        case (state_q)
            IDLE: begin
                if (inst_cand || data_cand) begin
                    grant_v   = 1'b1;
                    mem_req_d = 1'b1;
                    if (winner == OWN_DATA) begin
                        state_d     = DATA;
                        mem_we_d    = bus.data_we;
                        mem_addr_d  = bus.data_addr;
                        mem_wdata_d = bus.data_wdata;
                    end else begin
                        state_d    = INST;
                        mem_we_d   = 1'b0;
                        mem_addr_d = bus.inst_addr;
                    end
                end
            end
            INST: begin
                if (bus.mem_ack) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    inst_ready_d = 1'b1;
                    inst_rdata_d = bus.mem_rdata;
                    last_grant_d = OWN_INST;
                end
            end
            DATA: begin
                if (bus.mem_ack) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    data_ready_d = 1'b1;
                    last_grant_d = OWN_DATA;
                    if (!mem_we_q) begin
                        data_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_INST;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.inst_ready = inst_ready_q;
    assign bus.data_ready = data_ready_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.stall_o    = inst_cand | data_cand;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] inst_grant_cnt_q, inst_grant_cnt_d;
    logic [31:0] data_grant_cnt_q, data_grant_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        inst_grant_cnt_d = inst_grant_cnt_q + 32'(grant_v && (winner == OWN_INST));
        data_grant_cnt_d = data_grant_cnt_q + 32'(grant_v && (winner == OWN_DATA));
        stall_cnt_d      = stall_cnt_q + 32'(inst_cand | data_cand);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_grant_cnt_q <= '0;
            data_grant_cnt_q <= '0;
            stall_cnt_q      <= '0;
        end else begin
            inst_grant_cnt_q <= inst_grant_cnt_d;
            data_grant_cnt_q <= data_grant_cnt_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign inst_grant_cnt = inst_grant_cnt_q;
    assign data_grant_cnt = data_grant_cnt_q;
    assign stall_cnt      = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus alternation,
// back-to-back transaction and (with ARB_PERF_CNT_EN) counter sequences.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] inst_grant_cnt;
    logic [31:0] data_grant_cnt;
    logic [31:0] stall_cnt;
`endif

    mem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .inst_grant_cnt (inst_grant_cnt),
        .data_grant_cnt (data_grant_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock cycle: inputs driven in that cycle, outputs expected in that cycle.
    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_irdy;
        logic        e_drdy;
        logic [31:0] e_irdata;
        logic [31:0] e_drdata;
        logic        e_stall;
        logic        bus_chk;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] RA = 32'h2008_0005;
    localparam logic [31:0] RB = 32'h1111_1111;
    localparam logic [31:0] RC = 32'h2222_2222;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    function automatic void row(input logic r, input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic dwe, input logic [31:0] daddr,
                                input logic [31:0] dwdata, input logic ack, input logic [31:0] rdata,
                                input logic e_req, input logic e_we, input logic [31:0] e_addr,
                                input logic [31:0] e_wdata, input logic e_irdy, input logic e_drdy,
                                input logic [31:0] e_irdata, input logic [31:0] e_drdata,
                                input logic e_stall, input logic bus_chk);
        vec_t v;
        v.rst = r;         v.ireq = ireq;       v.iaddr = iaddr;
        v.dreq = dreq;     v.dwe = dwe;         v.daddr = daddr;
        v.dwdata = dwdata; v.ack = ack;         v.rdata = rdata;
        v.e_req = e_req;   v.e_we = e_we;       v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_irdy = e_irdy; v.e_drdy = e_drdy;
        v.e_irdata = e_irdata; v.e_drdata = e_drdata;
        v.e_stall = e_stall; v.bus_chk = bus_chk;
        vecs.push_back(v);
    endfunction

    task automatic apply_row(input vec_t v);
        rst            = v.rst;
        bus.inst_req   = v.ireq;
        bus.inst_addr  = v.iaddr;
        bus.data_req   = v.dreq;
        bus.data_we    = v.dwe;
        bus.data_addr  = v.daddr;
        bus.data_wdata = v.dwdata;
        bus.mem_ack    = v.ack;
        bus.mem_rdata  = v.rdata;
    endtask

    task automatic check_row(input int idx, input vec_t v);
        logic ok;
        ok = (bus.mem_req === v.e_req) && (bus.inst_ready === v.e_irdy) &&
             (bus.data_ready === v.e_drdy) && (bus.inst_rdata === v.e_irdata) &&
             (bus.data_rdata === v.e_drdata) && (bus.stall_o === v.e_stall);
        // Bus contents are only defined while a request is up or straight after reset.
        if (v.bus_chk) begin
            ok = ok && (bus.mem_we === v.e_we) && (bus.mem_addr === v.e_addr);
            if (v.e_we || !v.e_req) ok = ok && (bus.mem_wdata === v.e_wdata);
        end
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL row%0d: got req=%0b we=%0b addr=%h wdata=%h irdy=%0b drdy=%0b irdata=%h drdata=%h stall=%0b want req=%0b we=%0b addr=%h wdata=%h irdy=%0b drdy=%0b irdata=%h drdata=%h stall=%0b",
                     idx, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.inst_ready,
                     bus.data_ready, bus.inst_rdata, bus.data_rdata, bus.stall_o,
                     v.e_req, v.e_we, v.e_addr, v.e_wdata, v.e_irdy, v.e_drdy,
                     v.e_irdata, v.e_drdata, v.e_stall);
        end
    endtask

    // One complete transaction with mem_ack in the first mem_req cycle; starts at posedge+1.
    task automatic do_txn(input logic is_data, input logic [31:0] addr, input logic [31:0] val);
        if (is_data) begin
            bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = addr;
        end else begin
            bus.inst_req = 1'b1; bus.inst_addr = addr;
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b1; bus.mem_rdata = val;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        tests++;
        if (is_data ? !(bus.data_ready === 1'b1 && bus.inst_ready === 1'b0 && bus.data_rdata === val)
                    : !(bus.inst_ready === 1'b1 && bus.data_ready === 1'b0 && bus.inst_rdata === val)) begin
            failed++;
            $display("FAIL txn %s addr=%h: got irdy=%0b drdy=%0b irdata=%h drdata=%h want rdata=%h",
                     is_data ? "data" : "inst", addr, bus.inst_ready, bus.data_ready,
                     bus.inst_rdata, bus.data_rdata, val);
        end
        @(posedge clk); #1;
        bus.inst_req = 1'b0; bus.data_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_seen;
        logic exp_data;
        tests  = 0;
        failed = 0;

        // fetch of 0x4, ack in first mem_req cycle, ready two cycles after request
        row(1,0,0,      0,0,0,0,       0,0,            0,0,0,0,      0,0,0,0,   0,1);
        row(0,1,4,      0,0,0,0,       0,0,            0,0,0,0,      0,0,0,0,   1,1);
        row(0,1,4,      0,0,0,0,       1,RA,           1,0,4,0,      0,0,0,0,   1,1);
        row(0,1,4,      0,0,0,0,       0,0,            0,0,0,0,      1,0,RA,0,  0,0);
        row(0,0,0,      0,0,0,0,       0,0,            0,0,0,0,      0,0,RA,0,  0,0);
        // both at once after reset: DATA first, INST granted in the data_ready cycle
        row(1,0,0,      0,0,0,0,       0,0,            0,0,0,0,      0,0,RA,0,  0,0);
        row(0,1,8,      1,0,'h10,0,    0,0,            0,0,0,0,      0,0,0,0,   1,1);
        row(0,1,8,      1,0,'h10,0,    0,0,            1,0,'h10,0,   0,0,0,0,   1,1);
        row(0,1,8,      1,0,'h10,0,    1,RB,           1,0,'h10,0,   0,0,0,0,   1,1);
        row(0,1,8,      1,0,'h10,0,    0,0,            0,0,0,0,      0,1,0,RB,  1,0);
        row(0,1,8,      0,0,0,0,       0,0,            1,0,8,0,      0,0,0,RB,  1,1);
        row(0,1,8,      0,0,0,0,       1,RC,           1,0,8,0,      0,0,0,RB,  1,1);
        row(0,1,8,      0,0,0,0,       0,0,            0,0,0,0,      1,0,RC,RB, 0,0);
        row(0,0,0,      0,0,0,0,       0,0,            0,0,0,0,      0,0,RC,RB, 0,0);
        // write 0x20 <- DEADBEEF, ack on third mem_req cycle; bus held though inputs change
        row(0,0,0,      1,1,'h20,DB,   0,0,            0,0,0,0,      0,0,RC,RB, 1,0);
        row(0,0,0,      1,1,'h20,DB,   0,0,            1,1,'h20,DB,  0,0,RC,RB, 1,1);
        row(0,0,0,      1,1,'h44,0,    0,0,            1,1,'h20,DB,  0,0,RC,RB, 1,1);
        row(0,0,0,      1,1,'h20,DB,   1,'h33333333,   1,1,'h20,DB,  0,0,RC,RB, 1,1);
        row(0,0,0,      1,1,'h20,DB,   0,0,            0,0,0,0,      0,1,RC,RB, 0,0);
        row(0,0,0,      0,0,0,0,       0,0,            0,0,0,0,      0,0,RC,RB, 0,0);
        // stray mem_ack while idle
        row(0,0,0,      0,0,0,0,       1,'h55555555,   0,0,0,0,      0,0,RC,RB, 0,0);
        row(0,0,0,      0,0,0,0,       0,0,            0,0,0,0,      0,0,RC,RB, 0,0);
        // reset while DATA waits for ack, then a late ack
        row(0,0,0,      1,0,'h30,0,    0,0,            0,0,0,0,      0,0,RC,RB, 1,0);
        row(0,0,0,      1,0,'h30,0,    0,0,            1,0,'h30,0,   0,0,RC,RB, 1,1);
        row(1,0,0,      1,0,'h30,0,    0,0,            1,0,'h30,0,   0,0,RC,RB, 1,1);
        row(0,0,0,      0,0,0,0,       1,'h66666666,   0,0,0,0,      0,0,0,0,   0,1);
        row(0,0,0,      0,0,0,0,       0,0,            0,0,0,0,      0,0,0,0,   0,1);

        apply_row(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply_row(vecs[i]);
            @(negedge clk);
            check_row(i, vecs[i]);
            @(posedge clk); #1;
        end

        // Both requesters continuously busy: completions must alternate D, I, D, I.
        bus.inst_req = 1'b1; bus.inst_addr = 32'h100;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h200;
        bus.mem_ack = 1'b0;
        n_seen = 0;
        for (int c = 0; c < 40 && n_seen < 4; c++) begin
            @(negedge clk);
            if (bus.inst_ready || bus.data_ready) begin
                exp_data = (n_seen % 2 == 0);
                tests++;
                if (!(bus.data_ready === exp_data && bus.inst_ready === !exp_data)) begin
                    failed++;
                    $display("FAIL alternate #%0d: got irdy=%0b drdy=%0b want %s",
                             n_seen, bus.inst_ready, bus.data_ready, exp_data ? "data" : "inst");
                end
                n_seen++;
            end
            @(posedge clk); #1;
            bus.mem_ack   = bus.mem_req;
            bus.mem_rdata = 32'hA000_0000 + 32'(c);
        end
        tests++;
        if (n_seen < 4) begin
            failed++;
            $display("FAIL alternate timeout: got %0d completions want 4", n_seen);
        end

        bus.inst_req = 1'b0; bus.data_req = 1'b0; bus.mem_ack = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 3 fetches + 2 loads back to back, 2 stall cycles each
        do_txn(1'b0, 32'h0000_0040, 32'h0101_0101);
        do_txn(1'b1, 32'h0000_0080, 32'h0202_0202);
        do_txn(1'b0, 32'h0000_0044, 32'h0303_0303);
        do_txn(1'b1, 32'h0000_0084, 32'h0404_0404);
        do_txn(1'b0, 32'h0000_0048, 32'h0505_0505);
        repeat (2) @(posedge clk);
        @(negedge clk);

`ifdef ARB_PERF_CNT_EN
        tests++;
        if (inst_grant_cnt !== 32'd3) begin
            failed++;
            $display("FAIL inst_grant_cnt: got %0d want 3", inst_grant_cnt);
        end
        tests++;
        if (data_grant_cnt !== 32'd2) begin
            failed++;
            $display("FAIL data_grant_cnt: got %0d want 2", data_grant_cnt);
        end
        tests++;
        if (stall_cnt !== 32'd10) begin
            failed++;
            $display("FAIL stall_cnt: got %0d want 10", stall_cnt);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of data buses.
REQ-002 Parameter: ADDR_W, 32, width of address buses.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 inst_req  in  1  fetch request; held high until inst_ready.
REQ-006 inst_addr  in  ADDR_W  fetch address (pcF).
REQ-007 inst_ready  out  1  one-cycle completion pulse, fetch.
REQ-008 inst_rdata  out  DATA_W  fetched word (instrF); valid when inst_ready.
REQ-009 data_req / data_we  in  1 / 1  data request; write enable (memwriteM).
REQ-010 data_addr / data_wdata  in  ADDR_W / DATA_W  aluoutM / writedataM.
REQ-011 data_ready  out  1  one-cycle completion pulse, data.
REQ-012 data_rdata  out  DATA_W  load word (readdataM); valid when data_ready on a read.
REQ-013 mem_req / mem_we  out  1 / 1  shared memory port request and write enable.
REQ-014 mem_addr / mem_wdata  out  ADDR_W / DATA_W  shared port address, write data.
REQ-015 mem_ack / mem_rdata  in  1 / DATA_W  memory completion; read data valid with mem_ack.
REQ-016 stall_o  out  1  pipeline freeze = (inst_req & ~inst_ready) | (data_req & ~data_ready).

Function
REQ-017 FSM states IDLE, INST, DATA; one outstanding memory transaction at most.
REQ-018 IDLE: data_req only -> DATA; inst_req only -> INST; neither -> IDLE.
REQ-019 IDLE, both requesting: grant the requester not granted last (last_grant flag); equal history resolves to DATA.
REQ-020 On grant, mem_addr/mem_we/mem_wdata register from the winner; mem_req=1 from next cycle; mem_we=0 for INST.
REQ-021 mem_req and mem_* outputs stay stable in INST/DATA until the cycle mem_ack=1 is sampled.
REQ-022 mem_ack sampled at cycle M: at M+1 matching *_ready=1 for exactly one cycle, *_rdata=mem_rdata captured at M, state=IDLE, mem_req=0, last_grant updated.
REQ-023 In the ready cycle, the completing requester's req is masked from arbitration; the other requester may be granted that cycle.
REQ-024 Minimum turnaround: request at N, mem_ack at N+1 -> ready at N+2.
REQ-025 data write completion: data_ready pulses; data_rdata holds its previous value.
REQ-026 inst_rdata/data_rdata hold value between pulses.
REQ-027 mem_ack in IDLE is ignored.

Reset
REQ-028 rst: state=IDLE, last_grant=INST, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, both ready=0, both rdata=0.
REQ-029 rst mid-transaction aborts it: no ready pulse generated; late mem_ack ignored.

Configuration
REQ-030 ARB_PERF_CNT_EN defined: adds outputs inst_grant_cnt, data_grant_cnt, stall_cnt (32 bits each), reset to 0, increment on each grant / each stall_o cycle, wrap at 2^32.
REQ-031 ARB_PERF_CNT_EN undefined: counters and ports absent; all other behaviour identical.

Structure
REQ-032 Shared package holds the FSM state enumeration (IDLE, INST, DATA) and grant-owner encoding.
REQ-033 No sub-module; optional counters live inside the same module.

Verification
REQ-034 inst_req, addr 0x00000004, mem_ack one cycle after mem_req with 0x20080005 -> inst_ready at +2, inst_rdata=0x20080005, mem_we=0.
REQ-035 inst_req and data_req (read 0x10) same cycle after reset -> DATA granted first, then INST in the data_ready cycle; stall_o high throughout.
REQ-036 data write addr 0x20 data 0xDEADBEEF, mem_ack after 3 cycles -> mem_we=1, stable mem_addr/mem_wdata 3 cycles, data_ready pulse, data_rdata unchanged.
REQ-037 Continuous requests from both -> grants alternate DATA, INST, DATA, INST; no requester waits more than one transaction.
REQ-038 rst asserted while in DATA awaiting mem_ack -> IDLE next cycle, mem_req=0, no data_ready; late mem_ack ignored.
REQ-039 With ARB_PERF_CNT_EN: 3 fetches + 2 loads -> inst_grant_cnt=3, data_grant_cnt=2, stall_cnt = number of stall_o cycles.
